// File: rtl/universal_shift_register_pkg.sv
// Shared types for the universal shift register: operation modes, burst FSM
// states and the shift-class predicate used to decide whether a start launches a burst.
package usr_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    SHR  = 3'd1,
    SHL  = 3'd2,
    LOAD = 3'd3,
    ROTR = 3'd4,
    ROTL = 3'd5,
    ASR  = 3'd6,
    CLR  = 3'd7
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic is_shift(input mode_e m);
    return (m == SHR) || (m == SHL) || (m == ROTR) || (m == ROTL) || (m == ASR);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Control/data bundle of the universal shift register. The master side drives
// mode, serial/parallel data and burst requests; the slave side returns the register and status.
interface universal_shift_register_if import usr_pkg::*; #(
  parameter int MSB = 4
) ();
  localparam int CW = $clog2(MSB + 1);

  logic           en;
  mode_e          mode;
  logic           d_r;
  logic           d_l;
  logic [MSB-1:0] par_in;
  logic           start;
  logic [CW-1:0]  shamt;
  logic [MSB-1:0] out;
  logic           so_r;
  logic           so_l;
  logic           busy;
  logic           done;
  state_e         state_dbg;

  modport master (
    output en, mode, d_r, d_l, par_in, start, shamt,
    input  out, so_r, so_l, busy, done, state_dbg
  );

  modport slave (
    input  en, mode, d_r, d_l, par_in, start, shamt,
    output out, so_r, so_l, busy, done, state_dbg
  );
endinterface

// File: rtl/universal_shift_register_next_value.sv
// Combinational next-register function for one mode step; shared by the
// manual path and the burst engine.
module usr_next_value import usr_pkg::*; #(
  parameter int MSB = 4
) (
  input  logic [MSB-1:0] cur,
  input  mode_e          mode,
  input  logic           d_r,
  input  logic           d_l,
  input  logic [MSB-1:0] par_in,
  output logic [MSB-1:0] nxt
);
  always_comb begin
    nxt = cur;
    case (mode)
      HOLD:    nxt = cur;
      SHR:     nxt = {d_r, cur[MSB-1:1]};
      SHL:     nxt = {cur[MSB-2:0], d_l};
      LOAD:    nxt = par_in;
      ROTR:    nxt = {cur[0], cur[MSB-1:1]};
      ROTL:    nxt = {cur[MSB-2:0], cur[MSB-1]};
      ASR:     nxt = {cur[MSB-1], cur[MSB-1:1]};
      CLR:     nxt = '0;
      default: nxt = cur;
    endcase
  end
endmodule

// File: rtl/universal_shift_register.sv
// MSB-bit eight-mode shift register with a burst engine that repeats a
// shift/rotate shamt times (0 means MSB) from one start pulse, then pulses done.
module universal_shift_register import usr_pkg::*; #(
  parameter int MSB = 4
) (
  input logic clk,
  input logic rst,
  universal_shift_register_if.slave bus
);
  localparam int CW = $clog2(MSB + 1);

  state_e         state_q, state_d;
  mode_e          burst_mode_q, burst_mode_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [MSB-1:0] out_q, out_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  mode_e          op_mode;
  logic [MSB-1:0] nxt;
  logic [CW-1:0]  first_cnt;

  usr_next_value #(.MSB(MSB)) u_next (
    .cur    (out_q),
    .mode   (op_mode),
    .d_r    (bus.d_r),
    .d_l    (bus.d_l),
    .par_in (bus.par_in),
    .nxt    (nxt)
  );

  always_comb begin
    first_cnt    = (bus.shamt == '0) ? CW'(MSB) : bus.shamt;
    op_mode      = (state_q == RUN) ? burst_mode_q : bus.mode;
    state_d      = state_q;
    burst_mode_d = burst_mode_q;
    cnt_d        = cnt_q;
    out_d        = out_q;
    done_d       = 1'b0;
    if (bus.en) begin
      out_d = nxt;
      case (state_q)
        IDLE: begin
          // The launching cycle already performs the first step.
          if (bus.start && is_shift(bus.mode)) begin
            burst_mode_d = bus.mode;
            if (first_cnt == CW'(1)) begin
              cnt_d  = '0;
              done_d = 1'b1;
            end else begin
              state_d = RUN;
              cnt_d   = first_cnt - CW'(1);
            end
          end
        end
        RUN: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
  end

  // done is not gated by en, so the pulse always lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_mode_q <= HOLD;
      cnt_q        <= '0;
      out_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_mode_q <= burst_mode_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.so_r      = out_q[0];
  assign bus.so_l      = out_q[MSB-1];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for the 4-bit universal shift register: manual modes, bursts,
// en stalls, ignored starts and asynchronous reset, all against hand-computed values.
module tb_universal_shift_register;
  import usr_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  universal_shift_register_if #(.MSB(4)) bus ();

  universal_shift_register #(.MSB(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [3:0] exp_out,
                              input logic exp_busy, input logic exp_done);
    check({tag, "_out"},  32'(bus.out),  32'(exp_out));
    check({tag, "_busy"}, 32'(bus.busy), 32'(exp_busy));
    check({tag, "_done"}, 32'(bus.done), 32'(exp_done));
  endtask

  initial begin
    bus.en = 1'b0; bus.mode = HOLD; bus.d_r = 1'b0; bus.d_l = 1'b0;
    bus.par_in = 4'b0000; bus.start = 1'b0; bus.shamt = 3'd0;

    // Reset state
    #12;
    check_status("reset", 4'b0000, 1'b0, 1'b0);
    check("reset_state", 32'(bus.state_dbg), 32'(IDLE));
    rst = 1'b0;

    // 1. load, then asynchronous reset mid-cycle
    bus.en = 1'b1; bus.mode = LOAD; bus.par_in = 4'b1011;
    tick();
    check_status("load", 4'b1011, 1'b0, 1'b0);
    check("load_so_r", 32'(bus.so_r), 32'd1);
    check("load_so_l", 32'(bus.so_l), 32'd1);
    #2 rst = 1'b1;
    #1 check("async_rst_out", 32'(bus.out), 32'd0);
    rst = 1'b0;

    // 2. manual SHR, SHL, ASR
    tick();
    check("reload", 32'(bus.out), 32'b1011);
    bus.mode = SHR; bus.d_r = 1'b1;
    tick(); check("shr1", 32'(bus.out), 32'b1101);
    tick(); check("shr2", 32'(bus.out), 32'b1110);
    check("shr2_so_r", 32'(bus.so_r), 32'd0);
    bus.mode = SHL; bus.d_l = 1'b0;
    tick(); check("shl1", 32'(bus.out), 32'b1100);
    bus.mode = ASR;
    tick(); check("asr1", 32'(bus.out), 32'b1110);

    // 3. ROTR burst of 3 from 1001
    bus.mode = LOAD; bus.par_in = 4'b1001;
    tick();
    bus.mode = ROTR; bus.shamt = 3'd3; bus.start = 1'b1;
    tick(); check_status("rotr3_s1", 4'b1100, 1'b1, 1'b0);
    check("rotr3_state", 32'(bus.state_dbg), 32'(RUN));
    bus.start = 1'b0; bus.mode = HOLD;
    tick(); check_status("rotr3_s2", 4'b0110, 1'b1, 1'b0);
    tick(); check_status("rotr3_s3", 4'b0011, 1'b0, 1'b1);
    tick(); check_status("rotr3_after", 4'b0011, 1'b0, 1'b0);

    // 4. ROTL burst with shamt=0 means 4 steps
    bus.mode = LOAD; bus.par_in = 4'b0001;
    tick();
    bus.mode = ROTL; bus.shamt = 3'd0; bus.start = 1'b1;
    tick(); check_status("rotl0_s1", 4'b0010, 1'b1, 1'b0);
    bus.start = 1'b0; bus.mode = HOLD;
    tick(); check_status("rotl0_s2", 4'b0100, 1'b1, 1'b0);
    tick(); check_status("rotl0_s3", 4'b1000, 1'b1, 1'b0);
    tick(); check_status("rotl0_s4", 4'b0001, 1'b0, 1'b1);
    tick(); check_status("rotl0_after", 4'b0001, 1'b0, 1'b0);

    // 5. burst stalled by en=0 with a CLR start that must be ignored
    bus.mode = LOAD; bus.par_in = 4'b1001;
    tick();
    bus.mode = ROTR; bus.shamt = 3'd3; bus.start = 1'b1;
    tick(); check_status("stall_s1", 4'b1100, 1'b1, 1'b0);
    bus.en = 1'b0; bus.mode = CLR; bus.start = 1'b1;
    tick(); check_status("stall_hold1", 4'b1100, 1'b1, 1'b0);
    tick(); check_status("stall_hold2", 4'b1100, 1'b1, 1'b0);
    bus.en = 1'b1;
    tick(); check_status("stall_s2", 4'b0110, 1'b1, 1'b0);
    tick(); check_status("stall_s3", 4'b0011, 1'b0, 1'b1);
    bus.start = 1'b0; bus.mode = HOLD; bus.en = 1'b0;
    tick(); check_status("done_drops_en0", 4'b0011, 1'b0, 1'b0);

    // IDLE start ignored while en=0
    bus.mode = ROTR; bus.start = 1'b1;
    tick(); check_status("idle_en0_start", 4'b0011, 1'b0, 1'b0);
    bus.start = 1'b0; bus.en = 1'b1;

    // shamt=1: single step, stays IDLE, done next cycle
    bus.mode = SHL; bus.d_l = 1'b1; bus.shamt = 3'd1; bus.start = 1'b1;
    tick(); check_status("shamt1", 4'b0111, 1'b0, 1'b1);
    bus.start = 1'b0; bus.mode = HOLD;
    tick(); check_status("shamt1_after", 4'b0111, 1'b0, 1'b0);

    // 6. start with LOAD is a manual load
    bus.mode = LOAD; bus.par_in = 4'b0101; bus.start = 1'b1;
    tick(); check_status("start_load1", 4'b0101, 1'b0, 1'b0);
    tick(); check_status("start_load2", 4'b0101, 1'b0, 1'b0);
    bus.mode = ROTR; bus.shamt = 3'd3;
    tick(); check_status("rst_burst_s1", 4'b1010, 1'b1, 1'b0);
    bus.start = 1'b0; bus.mode = HOLD;
    tick(); check_status("rst_burst_s2", 4'b0101, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_status("rst_mid_burst", 4'b0000, 1'b0, 1'b0);
    check("rst_mid_state", 32'(bus.state_dbg), 32'(IDLE));
    rst = 1'b0;
    bus.mode = SHR; bus.d_r = 1'b1; bus.shamt = 3'd2; bus.start = 1'b1;
    tick(); check_status("post_rst_s1", 4'b1000, 1'b1, 1'b0);
    bus.start = 1'b0; bus.mode = HOLD;
    tick(); check_status("post_rst_s2", 4'b1100, 1'b0, 1'b1);
    tick(); check_status("post_rst_after", 4'b1100, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
